cl_boot_mailbox_ctrl: RTL and testbench

Custom-logic block on the BAR1 AXI-Lite path that owns the host/core boot handshake after the host has DMA-loaded a program image into DDR. It holds the to-host and from-host mailbox registers and a status/cycle-count register. It sequences the core reset from virtual DIP bit 0 and reports completion on virtual LEDs. Core writes to to-host take priority over host writes.

---
 rtl/cl_boot_mailbox_ctrl_if.sv | 35 +++
 rtl/cl_boot_mailbox_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cl_boot_mailbox_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_boot_mailbox_ctrl_if.sv
// AXI-Lite slave bundle for the boot mailbox register window on BAR1.
// Signal names match the original flat port list so the host-side wiring maps one to one.
interface cl_boot_mailbox_ctrl_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/cl_boot_mailbox_ctrl.sv
// Host/core boot handshake: to-host/from-host mailboxes, status and run-cycle counter,
// plus core reset sequencing from vdip[0] and completion reporting on vled.
module cl_boot_mailbox_ctrl #(
    parameter logic [31:0] MBOX_BASE       = 32'h0008_C000,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                         clk_main_a0,
    input  logic                         rst_main_n,
    cl_boot_mailbox_ctrl_if.slave        bus,
    input  logic [15:0]                  vdip,
    output logic [15:0]                  vled,
    output logic                         core_rst_n,
    input  logic                         core_tohost_we,
    input  logic [31:0]                  core_tohost_wdata,
    output logic [31:0]                  fromhost
);

    localparam int unsigned HC_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD_CYCLES - 1);

    localparam logic [9:0] OFF_STATUS   = 10'h040;
    localparam logic [9:0] OFF_TOHOST   = 10'h048;
    localparam logic [9:0] OFF_FROMHOST = 10'h04A;
    localparam logic [9:0] OFF_CYCLE    = 10'h04C;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q, pass_q, core_rst_n_q;
    logic [31:0]       tohost_q, fromhost_q;

    logic              rst_done;
    logic              aw_held, w_held, bvalid_q, rvalid_q;
    logic [31:2]       aw_addr_q;
    logic [31:0]       w_data_q, rdata_q, rd_mux;
    logic [3:0]        w_strb_q;

    logic run_req, enter_release, core_active, core_we_eff;
    logic aw_hs, w_hs, ar_hs, commit, wr_hit, wr_tohost, wr_fromhost;
    logic unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign run_req       = vdip[0];
    assign enter_release = (state_q == ST_HOLD) && (state_d == ST_RELEASE);
    assign core_active   = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign core_we_eff   = core_tohost_we && core_active;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD:    if (run_req) state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!run_req)                     state_d = ST_HOLD;
                else if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!run_req)            state_d = ST_HOLD;
                else if (core_tohost_we) state_d = ST_DONE;
            end
            ST_DONE:    if (!run_req) state_d = ST_HOLD;
            default:    state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= core_active;
            hold_cnt_q   <= (state_q == ST_RELEASE) ? hold_cnt_q + 1'b1 : '0;
            if (enter_release) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                pass_q <= 1'b0;
            end else begin
                if ((state_q == ST_RUN) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
                if ((state_q == ST_RUN) && core_tohost_we) begin
                    done_q <= 1'b1;
                    pass_q <= (core_tohost_wdata == 32'h0);
                end
            end
        end
    end

    // Readies stay low until the first clock after reset deasserts.
    assign bus.s_awready = rst_done && !aw_held && !bvalid_q;
    assign bus.s_wready  = rst_done && !w_held && !bvalid_q;
    assign bus.s_arready = rst_done && !rvalid_q;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bresp   = 2'b00;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = 2'b00;

    assign aw_hs  = bus.s_awvalid && bus.s_awready;
    assign w_hs   = bus.s_wvalid && bus.s_wready;
    assign ar_hs  = bus.s_arvalid && bus.s_arready;
    assign commit = aw_held && w_held;

    assign wr_hit      = (aw_addr_q[31:12] == MBOX_BASE[31:12]);
    assign wr_tohost   = commit && wr_hit && (aw_addr_q[11:2] == OFF_TOHOST);
    assign wr_fromhost = commit && wr_hit && (aw_addr_q[11:2] == OFF_FROMHOST);

    always_comb begin
        rd_mux = '0;
        if (bus.s_araddr[31:12] == MBOX_BASE[31:12]) begin
            case (bus.s_araddr[11:2])
                OFF_STATUS:   rd_mux = {28'b0, pass_q, done_q, state_q};
                OFF_TOHOST:   rd_mux = tohost_q;
                OFF_FROMHOST: rd_mux = fromhost_q;
                OFF_CYCLE:    rd_mux = 32'(cnt_q);
                default:      rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rst_done  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rst_done <= 1'b1;
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= bus.s_awaddr[31:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= bus.s_wdata;
                w_strb_q <= bus.s_wstrb;
            end
            if (bvalid_q && bus.s_bready) bvalid_q <= 1'b0;
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && bus.s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // A core write in the same cycle as a host commit wins; the host still gets OKAY.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            tohost_q   <= '0;
            fromhost_q <= '0;
        end else begin
            if (core_we_eff)    tohost_q <= core_tohost_wdata;
            else if (wr_tohost) tohost_q <= merge_bytes(tohost_q, w_data_q, w_strb_q);
            if (wr_fromhost)    fromhost_q <= merge_bytes(fromhost_q, w_data_q, w_strb_q);
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign fromhost   = fromhost_q;
    assign vled       = {12'b0, state_q, pass_q, done_q};

    assign unused_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0], vdip[15:1]};

endmodule

// File: tb/tb_cl_boot_mailbox_ctrl.sv
// Scoreboard bench for cl_boot_mailbox_ctrl: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them; sideband outputs are checked inline.
module tb_cl_boot_mailbox_ctrl;
    localparam logic [31:0] BASE = 32'h0008_C000;
    localparam int          HOLD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] vdip;
    logic [15:0] vled;
    logic        core_rst_n;
    logic        core_we;
    logic [31:0] core_wdata;
    logic [31:0] fromhost;

    always #5 clk = ~clk;

    cl_boot_mailbox_ctrl_if bus();

    cl_boot_mailbox_ctrl #(
        .MBOX_BASE(BASE),
        .RST_HOLD_CYCLES(HOLD),
        .CNT_W(32)
    ) dut (
        .clk_main_a0(clk),
        .rst_main_n(rst_n),
        .bus(bus),
        .vdip(vdip),
        .vled(vled),
        .core_rst_n(core_rst_n),
        .core_tohost_we(core_we),
        .core_tohost_wdata(core_wdata),
        .fromhost(fromhost)
    );

    int tests = 0;
    int fails = 0;
    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Response monitor: one pop per handshake, decoupled from the stimulus.
    always @(negedge clk) begin
        if (rst_n && bus.s_bvalid && bus.s_bready) begin
            if (exp_b.size() == 0) chk("unexpected_bresp", 32'(bus.s_bvalid), 32'h0);
            else                   chk("bresp", 32'(bus.s_bresp), 32'(exp_b.pop_front()));
        end
        if (rst_n && bus.s_rvalid && bus.s_rready) begin
            if (exp_r.size() == 0) chk("unexpected_rvalid", 32'(bus.s_rvalid), 32'h0);
            else begin
                chk("rdata", bus.s_rdata, exp_r.pop_front());
                chk("rresp", 32'(bus.s_rresp), 32'h0);
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        bit ok = 0;
        bus.s_awaddr  = a;
        bus.s_awvalid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.s_awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
        if (!ok) chk("aw_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        bus.s_wdata  = d;
        bus.s_wstrb  = s;
        bus.s_wvalid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.s_wready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.s_wvalid = 1'b0;
        if (!ok) chk("w_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 0;
        bus.s_araddr  = a;
        bus.s_arvalid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.s_arready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
        if (!ok) chk("ar_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_b.size() == 0 && exp_r.size() == 0) break;
            @(negedge clk);
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            chk("response_timeout", 32'(exp_b.size() + exp_r.size()), 32'h0);
            exp_b.delete();
            exp_r.delete();
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead);
        exp_b.push_back(2'b00);
        @(posedge clk); #1;
        fork
            send_w(d, s);
            begin
                if (lead > 0) begin repeat (lead) @(posedge clk); #1; end
                send_aw(a);
            end
        join
        drain();
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] e);
        exp_r.push_back(e);
        @(posedge clk); #1;
        send_ar(a);
        drain();
    endtask

    // Raise vdip[0]; count clocks after the sampling edge until core_rst_n is seen high.
    task automatic run_up(input string name);
        int n = 0;
        @(posedge clk); #1;
        vdip = 16'h0001;
        @(posedge clk);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (core_rst_n) break;
        end
        chk(name, 32'(n), 32'(HOLD + 1));
    endtask

    task automatic core_write(input logic [31:0] d);
        core_wdata = d;
        core_we    = 1'b1;
        @(posedge clk); #1;
        core_we    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b1;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b1;
        vdip = '0; core_we = 1'b0; core_wdata = '0;

        repeat (4) @(posedge clk);
        #1;
        chk("reset_handshake_outs",
            32'({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid}), 32'h0);
        chk("reset_core_rst_n", 32'(core_rst_n), 32'h0);
        chk("reset_vled", 32'(vled), 32'h0);
        chk("reset_fromhost", fromhost, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        axi_read(BASE + 32'h100, 32'h0);

        // W leads AW by 3 cycles, then a low-byte-only update.
        axi_write(BASE + 32'h120, 32'hDEAD_BEEF, 4'hF, 3);
        axi_read(BASE + 32'h120, 32'hDEAD_BEEF);
        axi_write(BASE + 32'h120, 32'h0000_0011, 4'b0001, 0);
        axi_read(BASE + 32'h120, 32'hDEAD_BE11);

        // Core strobe while held in HOLD must not touch TOHOST.
        @(posedge clk); #1;
        core_write(32'h0000_0077);
        axi_read(BASE + 32'h120, 32'hDEAD_BE11);

        axi_write(BASE + 32'h128, 32'h1234_5678, 4'hF, 0);
        chk("fromhost_port", fromhost, 32'h1234_5678);
        axi_read(BASE + 32'h128, 32'h1234_5678);

        // Unmapped and out-of-window accesses.
        axi_write(32'h0009_0128, 32'hFFFF_FFFF, 4'hF, 0);
        chk("fromhost_unmapped_write", fromhost, 32'h1234_5678);
        axi_read(BASE + 32'h1FC, 32'h0);
        axi_read(32'h0009_0120, 32'h0);

        // Abort release after 5 cycles of RELEASE.
        @(posedge clk); #1;
        vdip = 16'h0001;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("release_state", 32'(vled[3:2]), 32'h1);
        vdip = 16'h0000;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (core_rst_n) hi++;
        end
        chk("rst_low_after_drop", 32'(hi), 32'h0);
        chk("hold_after_drop", 32'(vled), 32'h0);

        // Full run: RUN entered one clock before core_rst_n rises, so the counter
        // is 1 here; 99 more clocks make 100 and the write edge adds the last one.
        run_up("rst_release_latency");
        repeat (99) @(posedge clk);
        #1;
        core_write(32'h0);
        chk("vled_done_pass", 32'(vled), 32'h000F);
        axi_read(BASE + 32'h100, 32'h0000_000F);
        axi_read(BASE + 32'h130, 32'd101);
        repeat (20) @(posedge clk);
        axi_read(BASE + 32'h130, 32'd101);
        axi_read(BASE + 32'h120, 32'h0);

        // Host and core hit TOHOST on the same edge (commit lands two clocks after issue).
        fork
            axi_write(BASE + 32'h120, 32'hAAAA_AAAA, 4'hF, 0);
            begin
                @(posedge clk);
                @(posedge clk); #1;
                core_wdata = 32'h5555_5555;
                core_we    = 1'b1;
                @(posedge clk); #1;
                core_we    = 1'b0;
            end
        join
        axi_read(BASE + 32'h120, 32'h5555_5555);
        chk("pass_kept_in_done", 32'(vled[1:0]), 32'h3);

        // Back to HOLD keeps done/pass until the next release; then a failing run.
        @(posedge clk); #1;
        vdip = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_core_rst_n", 32'(core_rst_n), 32'h0);
        chk("hold_vled", 32'(vled), 32'h0003);
        run_up("rst_release_latency_2");
        chk("run_cleared_flags", 32'(vled), 32'h0008);
        core_write(32'h3);
        chk("vled_done_fail", 32'(vled), 32'h000D);
        axi_read(BASE + 32'h100, 32'h0000_0007);

        // Stall the read channel for 10 clocks.
        bus.s_rready = 1'b0;
        exp_r.push_back(32'h0000_0003);
        @(posedge clk); #1;
        send_ar(BASE + 32'h120);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bus.s_rvalid || bus.s_arready || bus.s_rdata !== 32'h0000_0003) hi++;
        end
        chk("rready_stall_stable", 32'(hi), 32'h0);
        bus.s_rready = 1'b1;
        drain();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
